ship_placement_ctrl: RTL and testbench

Sequences the player's ship-placement phase of the Battleship board. It owns the cursor (i_actual, j_actual) during placement and validates each requested ship against board bounds and the existing occupancy. It writes accepted ships cell-by-cell into an 8x8 occupancy register and counts ships until the target is reached. It sits between the top-level game FSM (placing_ships in, finished_placing out) and the vga/decoder blocks.

---
 rtl/ship_placement_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ship_placement_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_placement_ctrl.sv
// Ship-placement phase sequencer: owns the cursor, validates requested ships
// against bounds and occupancy, writes them cell-by-cell and counts them.
module ship_placement_ctrl #(
  parameter int unsigned BOARD_N   = 8,
  parameter int unsigned MAX_SHIPS = 5,
  parameter int unsigned MAX_LEN   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         placing_ships,
  input  logic [2:0]                   amount_of_ships,
  input  logic                         move_up,
  input  logic                         move_down,
  input  logic                         move_left,
  input  logic                         move_right,
  input  logic                         orient,
  input  logic                         player_place_ship,
  output logic [2:0]                   i_actual,
  output logic [2:0]                   j_actual,
  output logic [2:0]                   ships_placed,
  output logic [2:0]                   cur_len,
  output logic [BOARD_N*BOARD_N-1:0]   occupancy,
  output logic                         busy,
  output logic                         place_error,
  output logic                         finished_placing
);

  localparam int unsigned OCC_W = BOARD_N * BOARD_N;
  localparam int unsigned IDX_W = $clog2(OCC_W);
  localparam int unsigned LIM   = BOARD_N - 1;
  localparam int unsigned BTN_W = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_CHECK  = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state, w_state_n;
  logic [BTN_W-1:0]   r_btn_q;
  logic [2:0]         r_i, r_j, r_ai, r_aj, r_k, r_target, r_ships, r_len;
  logic               r_orient, r_busy, r_err, r_fin;
  logic [OCC_W-1:0]   r_occ;

  logic [2:0]         w_i_n, w_j_n, w_ai_n, w_aj_n, w_k_n, w_target_n, w_ships_n, w_len_n;
  logic               w_orient_n, w_busy_n, w_err_n, w_fin_n;
  logic [OCC_W-1:0]   w_occ_n;

  logic [BTN_W-1:0]   w_btn, w_edge;
  logic [3:0]         w_ci, w_cj;
  logic [IDX_W-1:0]   w_idx;
  logic               w_oob, w_hit, w_last;
  logic [2:0]         w_tgt;

  // Length of ship n: max(MAX_LEN - n, 1)
  function automatic logic [2:0] len_of(input logic [2:0] n);
    int unsigned nn;
    nn = 32'(n);
    return (MAX_LEN > nn) ? 3'(MAX_LEN - nn) : 3'd1;
  endfunction

  // Bit order: {placing, place, right, left, down, up}
  assign w_btn  = {placing_ships, player_place_ship, move_right, move_left, move_down, move_up};
  assign w_edge = w_btn & ~r_btn_q;

  assign w_tgt = (32'(amount_of_ships) > MAX_SHIPS) ? 3'(MAX_SHIPS) : amount_of_ships;

  // Current cell in 4-bit arithmetic so running off the board is visible
  assign w_ci   = {1'b0, r_ai} + (r_orient ? {1'b0, r_k} : 4'd0);
  assign w_cj   = {1'b0, r_aj} + (r_orient ? 4'd0 : {1'b0, r_k});
  assign w_oob  = (w_ci > 4'(LIM)) || (w_cj > 4'(LIM));
  assign w_idx  = IDX_W'(w_ci[2:0]) * IDX_W'(BOARD_N) + IDX_W'(w_cj[2:0]);
  assign w_hit  = w_oob ? 1'b0 : r_occ[w_idx];
  assign w_last = (r_k == (r_len - 3'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_btn_q  <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_ai     <= '0;
      r_aj     <= '0;
      r_k      <= '0;
      r_target <= '0;
      r_ships  <= '0;
      r_len    <= 3'(MAX_LEN);
      r_orient <= 1'b0;
      r_occ    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_btn_q  <= w_btn;
      r_i      <= w_i_n;
      r_j      <= w_j_n;
      r_ai     <= w_ai_n;
      r_aj     <= w_aj_n;
      r_k      <= w_k_n;
      r_target <= w_target_n;
      r_ships  <= w_ships_n;
      r_len    <= w_len_n;
      r_orient <= w_orient_n;
      r_occ    <= w_occ_n;
      r_busy   <= w_busy_n;
      r_err    <= w_err_n;
      r_fin    <= w_fin_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_i_n      = r_i;
    w_j_n      = r_j;
    w_ai_n     = r_ai;
    w_aj_n     = r_aj;
    w_k_n      = r_k;
    w_target_n = r_target;
    w_ships_n  = r_ships;
    w_len_n    = r_len;
    w_orient_n = r_orient;
    w_occ_n    = r_occ;
    w_err_n    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_edge[5]) begin
          w_occ_n    = '0;
          w_ships_n  = '0;
          w_i_n      = '0;
          w_j_n      = '0;
          w_k_n      = '0;
          w_len_n    = len_of(3'd0);
          w_target_n = w_tgt;
          w_state_n  = (w_tgt == 3'd0) ? S_DONE : S_SELECT;
        end
      end
      S_SELECT: begin
        // Place beats any move in the same cycle; moves are prioritised up>down>left>right
        if (!placing_ships) begin
          w_state_n = S_IDLE;
        end else if (w_edge[4]) begin
          w_ai_n     = r_i;
          w_aj_n     = r_j;
          w_orient_n = orient;
          w_k_n      = '0;
          w_state_n  = S_CHECK;
        end else if (w_edge[0]) begin
          if (r_i != 3'd0) w_i_n = r_i - 3'd1;
        end else if (w_edge[1]) begin
          if (r_i != 3'(LIM)) w_i_n = r_i + 3'd1;
        end else if (w_edge[2]) begin
          if (r_j != 3'd0) w_j_n = r_j - 3'd1;
        end else if (w_edge[3]) begin
          if (r_j != 3'(LIM)) w_j_n = r_j + 3'd1;
        end
      end
      S_CHECK: begin
        if (!placing_ships) begin
          w_state_n = S_IDLE;
        end else if (w_oob || w_hit) begin
          w_err_n   = 1'b1;
          w_state_n = S_SELECT;
        end else if (w_last) begin
          w_k_n     = '0;
          w_state_n = S_WRITE;
        end else begin
          w_k_n = r_k + 3'd1;
        end
      end
      S_WRITE: begin
        if (!placing_ships) begin
          w_state_n = S_IDLE;
        end else begin
          w_occ_n[w_idx] = 1'b1;
          if (w_last) begin
            w_k_n     = '0;
            w_ships_n = r_ships + 3'd1;
            w_len_n   = len_of(r_ships + 3'd1);
            w_state_n = ((r_ships + 3'd1) == r_target) ? S_DONE : S_SELECT;
          end else begin
            w_k_n = r_k + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (!placing_ships) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n == S_CHECK) || (w_state_n == S_WRITE);
    w_fin_n  = (w_state_n == S_DONE);
  end

  assign i_actual         = r_i;
  assign j_actual         = r_j;
  assign ships_placed     = r_ships;
  assign cur_len          = r_len;
  assign occupancy        = r_occ;
  assign busy             = r_busy;
  assign place_error      = r_err;
  assign finished_placing = r_fin;

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Bench for ship_placement_ctrl: directed steps plus random moves/placements
// checked against a transaction-level board model.
module tb_ship_placement_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        placing_ships, move_up, move_down, move_left, move_right;
  logic        orient, player_place_ship;
  logic [2:0]  amount_of_ships;
  logic [2:0]  i_actual, j_actual, ships_placed, cur_len;
  logic [63:0] occupancy;
  logic        busy, place_error, finished_placing;

  int total = 0;
  int bad   = 0;

  int m_i, m_j, m_ships, m_target;
  bit m_sel, m_done;
  bit m_occ [8][8];

  ship_placement_ctrl dut (
    .clk(clk), .rst(rst), .placing_ships(placing_ships), .amount_of_ships(amount_of_ships),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .orient(orient), .player_place_ship(player_place_ship),
    .i_actual(i_actual), .j_actual(j_actual), .ships_placed(ships_placed), .cur_len(cur_len),
    .occupancy(occupancy), .busy(busy), .place_error(place_error),
    .finished_placing(finished_placing)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] occ_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (m_occ[i][j]) v[i*8+j] = 1'b1;
    return v;
  endfunction

  function automatic int m_len();
    return (5 - m_ships > 1) ? 5 - m_ships : 1;
  endfunction

  // Index of first offending cell of a ship, or -1 if it fits
  function automatic int first_bad(input int ai, input int aj, input int o, input int len);
    int ci, cj;
    for (int k = 0; k < len; k++) begin
      ci = ai + ((o != 0) ? k : 0);
      cj = aj + ((o != 0) ? 0 : k);
      if (ci > 7 || cj > 7) return k;
      if (m_occ[ci][cj]) return k;
    end
    return -1;
  endfunction

  task automatic chk_cursor(input string tag);
    chk({tag, ".i"}, i_actual, m_i);
    chk({tag, ".j"}, j_actual, m_j);
  endtask

  task automatic start_phase(input logic [2:0] amt);
    placing_ships = 1'b0;
    tick();
    tick();
    amount_of_ships = amt;
    placing_ships   = 1'b1;
    tick();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) m_occ[i][j] = 1'b0;
    m_ships  = 0;
    m_i      = 0;
    m_j      = 0;
    m_target = (amt > 3'd5) ? 5 : int'(amt);
    m_done   = (m_target == 0);
    m_sel    = !m_done;
    chk("phase.fin", finished_placing, m_done);
    chk("phase.ships", ships_placed, 0);
    chk("phase.len", cur_len, 5);
    chk("phase.occ", occupancy, occ_vec());
    chk("phase.busy", busy, 0);
    chk_cursor("phase");
  endtask

  task automatic press(input int d);
    case (d)
      0: move_up = 1'b1;
      1: move_down = 1'b1;
      2: move_left = 1'b1;
      default: move_right = 1'b1;
    endcase
    tick();
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    tick();
    if (m_sel) begin
      case (d)
        0: m_i = (m_i > 0) ? m_i - 1 : 0;
        1: m_i = (m_i < 7) ? m_i + 1 : 7;
        2: m_j = (m_j > 0) ? m_j - 1 : 0;
        default: m_j = (m_j < 7) ? m_j + 1 : 7;
      endcase
    end
    chk_cursor("move");
  endtask

  task automatic goto_cell(input int ti, input int tj);
    for (int n = 0; n < 16 && m_i > ti; n++) press(0);
    for (int n = 0; n < 16 && m_i < ti; n++) press(1);
    for (int n = 0; n < 16 && m_j > tj; n++) press(2);
    for (int n = 0; n < 16 && m_j < tj; n++) press(3);
  endtask

  task automatic place(input int o, input string tag);
    int len, fb, cnt, exp_cnt;
    len = m_len();
    fb  = first_bad(m_i, m_j, o, len);
    orient = (o != 0);
    player_place_ship = 1'b1;
    tick();
    player_place_ship = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    exp_cnt = (fb >= 0) ? fb + 1 : 2 * len;
    chk({tag, ".busy_cycles"}, cnt, exp_cnt);
    chk({tag, ".err"}, place_error, (fb >= 0));
    if (fb < 0) begin
      for (int k = 0; k < len; k++)
        m_occ[m_i + ((o != 0) ? k : 0)][m_j + ((o != 0) ? 0 : k)] = 1'b1;
      m_ships++;
      if (m_ships == m_target) begin
        m_done = 1'b1;
        m_sel  = 1'b0;
      end
    end
    chk({tag, ".ships"}, ships_placed, m_ships);
    chk({tag, ".len"}, cur_len, m_len());
    chk({tag, ".occ"}, occupancy, occ_vec());
    chk({tag, ".fin"}, finished_placing, m_done);
    chk_cursor(tag);
    tick();
    chk({tag, ".err_pulse"}, place_error, 0);
  endtask

  initial begin
    int found, fi, fj, fo;
    rst = 1'b1;
    placing_ships = 1'b0; amount_of_ships = 3'd0;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    orient = 1'b0; player_place_ship = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst.occ", occupancy, 0);
    chk("rst.ships", ships_placed, 0);
    chk("rst.len", cur_len, 5);
    chk("rst.i", i_actual, 0);
    chk("rst.j", j_actual, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err", place_error, 0);
    chk("rst.fin", finished_placing, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Two-ship phase: horizontal at (0,0), then vertical at (2,0)
    start_phase(3'd2);
    place(0, "s0");
    chk("s0.bits", occupancy, 64'h0000_0000_0000_001F);
    press(1);
    press(1);
    place(1, "s1");
    chk("s1.bits", occupancy, 64'h0000_0101_0101_001F);
    press(3);
    chk("done.frozen_j", j_actual, 0);
    placing_ships = 1'b0;
    tick();
    chk("done.fin_drop", finished_placing, 0);
    m_done = 1'b0;

    // Clamped target of 5; out-of-bounds, overlap and saturation cases
    start_phase(3'd7);
    for (int n = 0; n < 5; n++) press(3);
    place(0, "oob");
    for (int n = 0; n < 5; n++) press(2);
    place(0, "s0b");
    press(3);
    press(3);
    place(1, "ovl");
    for (int n = 0; n < 5; n++) press(2);
    move_right = 1'b1;
    repeat (20) tick();
    move_right = 1'b0;
    tick();
    m_j = 1;
    chk_cursor("hold");
    move_up = 1'b1; move_right = 1'b1;
    tick();
    move_up = 1'b0; move_right = 1'b0;
    tick();
    chk_cursor("up_right");

    // Random play against the model; amount change mid-phase must not matter
    amount_of_ships = 3'd1;
    for (int n = 0; n < 300 && !m_done; n++) begin
      if ($urandom_range(0, 2) == 2) place(int'($urandom_range(0, 1)), "rnd");
      else press(int'($urandom_range(0, 3)));
    end
    for (int s = 0; s < 5 && !m_done; s++) begin
      found = 0;
      for (int i = 0; i < 8 && found == 0; i++)
        for (int j = 0; j < 8 && found == 0; j++)
          for (int o = 0; o < 2 && found == 0; o++)
            if (first_bad(i, j, o, m_len()) < 0) begin
              found = 1; fi = i; fj = j; fo = o;
            end
      if (found != 0) begin
        goto_cell(fi, fj);
        place(fo, "fill");
      end
    end
    chk("clamp.ships", ships_placed, 5);
    chk("clamp.fin", finished_placing, 1);

    // Zero-ship phase finishes immediately
    start_phase(3'd0);
    chk("zero.fin", finished_placing, 1);

    // Abort mid-CHECK
    start_phase(3'd3);
    orient = 1'b0;
    player_place_ship = 1'b1;
    tick();
    player_place_ship = 1'b0;
    tick();
    chk("abort.busy_before", busy, 1);
    placing_ships = 1'b0;
    tick();
    m_sel = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.err", place_error, 0);
    chk("abort.fin", finished_placing, 0);
    tick();
    chk("abort.err_late", place_error, 0);
    press(3);

    // Asynchronous reset in the middle of WRITE
    start_phase(3'd2);
    orient = 1'b0;
    player_place_ship = 1'b1;
    tick();
    player_place_ship = 1'b0;
    repeat (7) tick();
    chk("wr.partial", occupancy, 64'h3);
    chk("wr.busy", busy, 1);
    #2;
    placing_ships = 1'b0;
    rst = 1'b0;
    #1;
    chk("wrst.occ", occupancy, 0);
    chk("wrst.ships", ships_placed, 0);
    chk("wrst.i", i_actual, 0);
    chk("wrst.j", j_actual, 0);
    chk("wrst.busy", busy, 0);
    chk("wrst.len", cur_len, 5);
    #1 rst = 1'b1;
    tick();
    chk("wrst.idle_fin", finished_placing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
